// File: rtl/slice_pkg.sv
// Shared types and constants for the katana slice-vector block.
// FSM state encoding and the frame-tick pixel position.
package slice_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } slice_state_e;

  localparam logic [10:0] H_TICK = 11'd1024;
  localparam logic [9:0]  V_TICK = 10'd768;

endpackage

// File: rtl/katana_history.sv
// Katana position history: tick-gated shift register plus saturating fill count.
// Entry 0 is the newest sample; lag_in selects the older sample for the vector.
module katana_history
  import slice_pkg::*;
#(
  parameter int DEPTH = 20,
  parameter int XW    = 11,
  parameter int YW    = 10
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       tick_in,
  input  logic [XW-1:0]              x_in,
  input  logic [YW-1:0]              y_in,
  input  logic [$clog2(DEPTH)-1:0]   lag_in,
  output logic [XW-1:0]              head_x,
  output logic [YW-1:0]              head_y,
  output logic [XW-1:0]              lag_x,
  output logic [YW-1:0]              lag_y,
  output logic [$clog2(DEPTH+1)-1:0] fill_out
);

  localparam int FW = $clog2(DEPTH + 1);

  logic [XW-1:0] x_r [DEPTH];
  logic [YW-1:0] y_r [DEPTH];
  logic [FW-1:0] fill_r;

  // Shift a new sample in on every frame tick and count valid entries.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
      fill_r <= '0;
    end else if (tick_in) begin
      x_r[0] <= x_in;
      y_r[0] <= y_in;
      for (int i = 1; i < DEPTH; i++) begin
        x_r[i] <= x_r[i-1];
        y_r[i] <= y_r[i-1];
      end
      if (fill_r != FW'(DEPTH)) begin
        fill_r <= fill_r + FW'(1);
      end
    end
  end

  assign head_x   = x_r[0];
  assign head_y   = y_r[0];
  assign lag_x    = x_r[lag_in];
  assign lag_y    = y_r[lag_in];
  assign fill_out = fill_r;

endmodule

// File: rtl/slice_vector.sv
// Katana swing vector: frame-tick detect, FILL/TRACK/HELD FSM and rise/run arithmetic.
// Optional speed magnitude and swing flag are built when SLICE_SPEED_EN is defined.
module slice_vector
  import slice_pkg::*;
#(
  parameter int DEPTH = 20,
  parameter int XW    = 11,
  parameter int YW    = 10,
  parameter int OW    = 12
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic [XW-1:0]            katana_x,
  input  logic [YW-1:0]            katana_y,
  input  logic                     split_in,
  input  logic [$clog2(DEPTH)-1:0] lag_in,
  output logic signed [OW-1:0]     rise_out,
  output logic signed [OW-1:0]     run_out,
  output logic                     vec_valid_out,
  input  logic [OW-1:0]            speed_thresh_in,
  output logic [OW:0]              speed_out,
  output logic                     swing_out
);

  localparam int LW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  // Magnitude of a signed value, widened so the most negative value fits.
  function automatic logic [OW:0] mag(input logic signed [OW-1:0] v);
    logic [OW:0] ext;
    ext = {v[OW-1], v};
    if (v[OW-1]) begin
      mag = -ext;
    end else begin
      mag = ext;
    end
  endfunction

  logic                cond_s, cond_d_r, tick_s;
  logic [LW-1:0]       lag_eff_s;
  logic [XW-1:0]       head_x_s, lag_x_s;
  logic [YW-1:0]       head_y_s, lag_y_s;
  logic [FW-1:0]       fill_s;
  logic                filled_s;
  logic signed [OW-1:0] rise_s, run_s;
  slice_state_e        state_r, state_nxt_s;
  logic                vec_valid_nxt_s;
  logic signed [OW-1:0] rise_r, run_r;
  logic [OW:0]         speed_r, speed_nxt_s;
  logic                vec_valid_r, swing_r, swing_nxt_s;

  assign cond_s = (hcount_in == H_TICK) && (vcount_in == V_TICK);
  assign tick_s = cond_s && !cond_d_r;

  katana_history #(
    .DEPTH (DEPTH),
    .XW    (XW),
    .YW    (YW)
  ) u_hist (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tick_in  (tick_s),
    .x_in     (katana_x),
    .y_in     (katana_y),
    .lag_in   (lag_eff_s),
    .head_x   (head_x_s),
    .head_y   (head_y_s),
    .lag_x    (lag_x_s),
    .lag_y    (lag_y_s),
    .fill_out (fill_s)
  );

  // Clamp the requested lag into 1..DEPTH-1.
  always_comb begin
    lag_eff_s = lag_in;
    if (lag_in == LW'(0)) begin
      lag_eff_s = LW'(1);
    end else if (lag_in > LW'(DEPTH - 1)) begin
      lag_eff_s = LW'(DEPTH - 1);
    end else begin
      lag_eff_s = lag_in;
    end
  end

  assign filled_s = fill_s > FW'(lag_eff_s);
  assign rise_s   = $signed({{(OW-YW){1'b0}}, head_y_s}) - $signed({{(OW-YW){1'b0}}, lag_y_s});
  assign run_s    = $signed({{(OW-XW){1'b0}}, head_x_s}) - $signed({{(OW-XW){1'b0}}, lag_x_s});

  // Next state and next validity; split always wins, HELD keeps validity from entry.
  always_comb begin
    state_nxt_s     = state_r;
    vec_valid_nxt_s = 1'b0;
    case (state_r)
      ST_FILL, ST_TRACK, ST_HELD: begin
        if (split_in) begin
          state_nxt_s = ST_HELD;
        end else if (filled_s) begin
          state_nxt_s = ST_TRACK;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      default: state_nxt_s = ST_FILL;
    endcase
    case (state_nxt_s)
      ST_TRACK: vec_valid_nxt_s = 1'b1;
      ST_HELD:  vec_valid_nxt_s = vec_valid_r;
      default:  vec_valid_nxt_s = 1'b0;
    endcase
  end

`ifdef SLICE_SPEED_EN
  assign speed_nxt_s = (state_nxt_s == ST_TRACK) ? (mag(rise_s) + mag(run_s)) : speed_r;
  assign swing_nxt_s = vec_valid_nxt_s && (speed_nxt_s >= {1'b0, speed_thresh_in});
`else
  logic unused_thresh_s;
  assign unused_thresh_s = ^speed_thresh_in;
  assign speed_nxt_s     = '0;
  assign swing_nxt_s     = 1'b0;
`endif

  // State, tick edge detector and registered outputs; vector loads only into TRACK.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cond_d_r    <= 1'b0;
      state_r     <= ST_FILL;
      rise_r      <= '0;
      run_r       <= '0;
      speed_r     <= '0;
      vec_valid_r <= 1'b0;
      swing_r     <= 1'b0;
    end else begin
      cond_d_r    <= cond_s;
      state_r     <= state_nxt_s;
      vec_valid_r <= vec_valid_nxt_s;
      swing_r     <= swing_nxt_s;
      speed_r     <= speed_nxt_s;
      if (state_nxt_s == ST_TRACK) begin
        rise_r <= rise_s;
        run_r  <= run_s;
      end
    end
  end

  assign rise_out      = rise_r;
  assign run_out       = run_r;
  assign speed_out     = speed_r;
  assign vec_valid_out = vec_valid_r;
  assign swing_out     = swing_r;

endmodule

// File: tb/tb_slice_vector.sv
// Scoreboard bench for slice_vector: directed frame ticks, expected tuples queued
// by the stimulus and compared by an independent monitor on the falling edge.
module tb_slice_vector;

`ifdef SLICE_SPEED_EN
  localparam bit SPEED_EN = 1'b1;
`else
  localparam bit SPEED_EN = 1'b0;
`endif

  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic [10:0]        katana_x;
  logic [9:0]         katana_y;
  logic               split_in;
  logic [4:0]         lag_in;
  logic signed [11:0] rise_out, run_out;
  logic               vec_valid_out;
  logic [11:0]        speed_thresh_in;
  logic [12:0]        speed_out;
  logic               swing_out;

  slice_vector dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .katana_x        (katana_x),
    .katana_y        (katana_y),
    .split_in        (split_in),
    .lag_in          (lag_in),
    .rise_out        (rise_out),
    .run_out         (run_out),
    .vec_valid_out   (vec_valid_out),
    .speed_thresh_in (speed_thresh_in),
    .speed_out       (speed_out),
    .swing_out       (swing_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string              tag;
    logic signed [11:0] rise;
    logic signed [11:0] run;
    logic               valid;
    logic [12:0]        speed;
    logic               swing;
    int                 fill;
    int                 hx;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_out(string tag, int r, int n, logic v, int fill, int hx);
    exp_t e;
    int   s;
    s       = iabs(r) + iabs(n);
    e.tag   = tag;
    e.rise  = 12'(r);
    e.run   = 12'(n);
    e.valid = v;
    e.speed = SPEED_EN ? 13'(s) : 13'd0;
    e.swing = SPEED_EN && v && (s >= int'(speed_thresh_in));
    e.fill  = fill;
    e.hx    = hx;
    q.push_back(e);
  endtask

  task automatic tick(int x, int y);
    katana_x  = 11'(x);
    katana_y  = 10'(y);
    hcount_in = 11'd1024;
    vcount_in = 10'd768;
    step();
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    step();
  endtask

  // Monitor: compare the oldest expectation against the settled outputs.
  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t e;
      int   fa, ha;
      e  = q.pop_front();
      fa = int'(dut.u_hist.fill_out);
      ha = int'(dut.u_hist.head_x);
      n_tests++;
      if (rise_out !== e.rise || run_out !== e.run || vec_valid_out !== e.valid ||
          speed_out !== e.speed || swing_out !== e.swing || fa != e.fill || ha != e.hx) begin
        n_fail++;
        $display("FAIL %s: got rise=%0d run=%0d valid=%b speed=%0d swing=%b fill=%0d hx=%0d, want rise=%0d run=%0d valid=%b speed=%0d swing=%b fill=%0d hx=%0d",
                 e.tag, rise_out, run_out, vec_valid_out, speed_out, swing_out, fa, ha,
                 e.rise, e.run, e.valid, e.speed, e.swing, e.fill, e.hx);
      end
    end
  end

  initial begin
    rst_n_in        = 1'b0;
    split_in        = 1'b1;
    hcount_in       = 11'd1024;
    vcount_in       = 10'd768;
    lag_in          = 5'd19;
    speed_thresh_in = 12'd57;
    katana_x        = 11'd100;
    katana_y        = 10'd50;
    repeat (3) step();
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    split_in  = 1'b0;
    step();
    expect_out("reset", 0, 0, 1'b0, 0, 0);
    rst_n_in = 1'b1;
    step();

    // A tick condition held three cycles must shift exactly once.
    hcount_in = 11'd1024;
    vcount_in = 10'd768;
    repeat (3) step();
    expect_out("hold_one_tick", 0, 0, 1'b0, 1, 100);
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    step();

    for (int k = 1; k <= 18; k++) tick(100 + 2 * k, 50 + k);
    expect_out("fill19_invalid", 0, 0, 1'b0, 19, 136);
    tick(138, 69);
    expect_out("track_pos", 19, 38, 1'b1, 20, 138);
    speed_thresh_in = 12'd58;
    step();
    expect_out("thresh58", 19, 38, 1'b1, 20, 138);
    speed_thresh_in = 12'd57;
    step();

    for (int k = 0; k <= 19; k++) tick(500 - 2 * k, 300 - k);
    expect_out("track_neg", -19, -38, 1'b1, 20, 462);

    // Split rises together with the first tick: the held values are pre-tick.
    split_in = 1'b1;
    for (int j = 1; j <= 5; j++) tick(462 - 10 * j, 281 - 5 * j);
    expect_out("held_frozen", -19, -38, 1'b1, 20, 412);
    split_in = 1'b0;
    step();
    expect_out("release", -39, -78, 1'b1, 20, 412);

    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    lag_in   = 5'd4;
    expect_out("reset2", 0, 0, 1'b0, 0, 0);
    step();
    for (int k = 0; k <= 5; k++) tick(10 + 3 * k, 20 + k);
    expect_out("lag4", 4, 12, 1'b1, 6, 25);
    lag_in = 5'd10;
    step();
    expect_out("lag10_fill", 4, 12, 1'b0, 6, 25);
    for (int k = 6; k <= 9; k++) tick(10 + 3 * k, 20 + k);
    expect_out("fill10", 4, 12, 1'b0, 10, 37);
    tick(40, 30);
    expect_out("lag10_track", 10, 30, 1'b1, 11, 40);
    lag_in = 5'd0;
    step();
    expect_out("lag0_as_1", 1, 3, 1'b1, 11, 40);
    lag_in = 5'd31;
    step();
    expect_out("lag31_clamped", 1, 3, 1'b0, 11, 40);

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
